// File: rtl/cap_bank_seq.sv
// cap_bank_seq: switches NSEG VCPHV charge-pump capacitor segments on/off one at a time, then confirms regulation.
// Latency: the first SEG_EN change follows REQ by one cycle; each segment is held SETTLE cycles; CHECK waits at most TIMEOUT cycles.
// Backpressure: a REQ while busy or faulted is dropped (no queuing); FAULT holds until CLR.
module cap_bank_seq #(
  parameter int NSEG    = 4,
  parameter int SW      = 3,
  parameter int CW      = 8,
  parameter int SETTLE  = 4,
  parameter int TIMEOUT = 8
) (
  input  logic            CLK,
  input  logic            RESET,
  input  logic            REQ,
  input  logic [SW-1:0]   TGT_SEG,
  input  logic            CLR,
  input  logic            VCPHV_OK,
  output logic [NSEG-1:0] SEG_EN,
  output logic            BUSY,
  output logic            READY,
  output logic            FAULT
);

  // UW holds any segment count 0..NSEG.
  localparam int            UW        = $clog2(NSEG + 1);
  localparam logic [UW-1:0] NSEG_U    = UW'(NSEG);
  localparam logic [CW-1:0] SETTLE_C  = CW'(SETTLE);
  localparam logic [CW-1:0] TIMEOUT_C = CW'(TIMEOUT);
  localparam logic [CW-1:0] CNT_ONE   = CW'(1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_UP,
    S_DOWN,
    S_CHECK,
    S_READY,
    S_FAULT
  } state_t;

  state_t        state, state_d;
  logic [UW-1:0] cur, cur_d;
  logic [UW-1:0] tgt, tgt_d;
  logic [UW-1:0] req_tgt;
  logic [CW-1:0] cnt, cnt_d;
  logic          ok_m, ok_s;

  // Two-flop synchroniser for the asynchronous comparator output.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      ok_m <= 1'b0;
      ok_s <= 1'b0;
    end else begin
      ok_m <= VCPHV_OK;
      ok_s <= ok_m;
    end
  end

  // Requested target saturated to the number of physical segments.
  always_comb begin
    req_tgt = UW'(TGT_SEG);
    if (int'(TGT_SEG) > NSEG) begin
      req_tgt = NSEG_U;
    end
  end

  // State, segment count, latched target and settle/timeout counter.
  always_ff @(posedge CLK or posedge RESET) begin
    if (RESET) begin
      state <= S_IDLE;
      cur   <= '0;
      tgt   <= '0;
      cnt   <= '0;
    end else begin
      state <= state_d;
      cur   <= cur_d;
      tgt   <= tgt_d;
      cnt   <= cnt_d;
    end
  end

  // Next-state logic: one segment per SETTLE interval, then a bounded wait for regulation.
  always_comb begin
    state_d = state;
    cur_d   = cur;
    tgt_d   = tgt;
    cnt_d   = cnt;
    case (state)
      S_IDLE, S_READY: begin
        // Loss of regulation while READY beats any request arriving in the same cycle.
        if ((state == S_READY) && !ok_s) begin
          state_d = S_FAULT;
          cur_d   = '0;
          cnt_d   = '0;
        end else if (REQ) begin
          tgt_d = req_tgt;
          if (req_tgt > cur) begin
            state_d = S_UP;
            cur_d   = cur + 1'b1;
            cnt_d   = SETTLE_C;
          end else if (req_tgt < cur) begin
            state_d = S_DOWN;
            cur_d   = cur - 1'b1;
            cnt_d   = SETTLE_C;
          end else if (req_tgt != '0) begin
            state_d = S_CHECK;
            cnt_d   = TIMEOUT_C;
          end
        end
      end
      S_UP: begin
        if (cnt == CNT_ONE) begin
          if (cur < tgt) begin
            cur_d = cur + 1'b1;
            cnt_d = SETTLE_C;
          end else begin
            state_d = S_CHECK;
            cnt_d   = TIMEOUT_C;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_DOWN: begin
        if (cnt == CNT_ONE) begin
          if (cur > tgt) begin
            cur_d = cur - 1'b1;
            cnt_d = SETTLE_C;
          end else if (tgt != '0) begin
            state_d = S_CHECK;
            cnt_d   = TIMEOUT_C;
          end else begin
            // Bank fully discharged: nothing to regulate.
            state_d = S_IDLE;
            cnt_d   = '0;
          end
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_CHECK: begin
        if (ok_s) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else if (cnt == CNT_ONE) begin
          state_d = S_FAULT;
          cur_d   = '0;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt - 1'b1;
        end
      end
      S_FAULT: begin
        cur_d = '0;
        if (CLR) begin
          state_d = S_IDLE;
        end
      end
      default: begin
        state_d = S_IDLE;
        cur_d   = '0;
        cnt_d   = '0;
      end
    endcase
  end

  // Thermometer decode of the registered segment count; bit0 switches first.
  always_comb begin
    SEG_EN = '0;
    for (int i = 0; i < NSEG; i++) begin
      SEG_EN[i] = (int'(cur) > i);
    end
  end

  assign BUSY  = (state == S_UP) || (state == S_DOWN) || (state == S_CHECK);
  assign READY = (state == S_READY);
  assign FAULT = (state == S_FAULT);

endmodule

// File: tb/tb_cap_bank_seq.sv
// tb_cap_bank_seq: directed bench for cap_bank_seq (NSEG=4, SETTLE=4, TIMEOUT=8).
// Expected SEG_EN steps (value and cycle) are queued when stimulus is driven and checked when SEG_EN moves.
// Status outputs are checked in-line, #1 after the rising edge.
module tb_cap_bank_seq;

  logic       CLK      = 1'b0;
  logic       RESET    = 1'b0;
  logic       REQ      = 1'b0;
  logic [2:0] TGT_SEG  = 3'd0;
  logic       CLR      = 1'b0;
  logic       VCPHV_OK = 1'b0;
  logic [3:0] SEG_EN;
  logic       BUSY;
  logic       READY;
  logic       FAULT;

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  typedef struct {
    logic [3:0] seg;
    int         at;
  } step_t;

  step_t      sbq[$];
  logic [3:0] seg_prev = 4'b0000;

  cap_bank_seq #(
    .NSEG(4), .SW(3), .CW(8), .SETTLE(4), .TIMEOUT(8)
  ) dut (
    .CLK(CLK), .RESET(RESET), .REQ(REQ), .TGT_SEG(TGT_SEG), .CLR(CLR),
    .VCPHV_OK(VCPHV_OK), .SEG_EN(SEG_EN), .BUSY(BUSY), .READY(READY), .FAULT(FAULT)
  );

  always #5 CLK = ~CLK;

  // Cycle index: after the k-th rising edge the bench is in cycle k.
  always @(posedge CLK) cyc <= cyc + 1;

  // Scoreboard: every SEG_EN change must match the next queued step, in value and cycle.
  always @(negedge CLK) begin
    if (SEG_EN !== seg_prev) begin
      n_tests++;
      if (sbq.size() == 0) begin
        n_fail++;
        $error("FAIL seg_unexpected: SEG_EN=%b at cyc %0d, required no change", SEG_EN, cyc);
      end else begin
        step_t e;
        e = sbq.pop_front();
        assert (SEG_EN === e.seg && cyc == e.at) else begin
          n_fail++;
          $error("FAIL seg_step: SEG_EN=%b at cyc %0d, required %b at cyc %0d", SEG_EN, cyc, e.seg, e.at);
        end
      end
      seg_prev = SEG_EN;
    end
  end

  task automatic push(input logic [3:0] s, input int at);
    step_t e;
    e.seg = s;
    e.at  = at;
    sbq.push_back(e);
  endtask

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  task automatic chk_bit(input string tag, input logic obs, input logic exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, required %b (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_seg(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: got %b, required %b (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  task automatic chk_int(input string tag, input int obs, input int exp);
    n_tests++;
    assert (obs == exp) else begin
      n_fail++;
      $error("FAIL %s: got %0d, required %0d (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached at cyc %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t;
    int s;

    // Reset state
    #2 RESET = 1'b1;
    #1;
    chk_seg("rst_seg", SEG_EN, 4'b0000);
    chk_bit("rst_busy", BUSY, 1'b0);
    chk_bit("rst_ready", READY, 1'b0);
    chk_bit("rst_fault", FAULT, 1'b0);
    ticks(2);
    RESET = 1'b0;
    tick();

    // Ramp up to 3 segments; comparator reports regulation at t+10
    t = cyc;
    REQ = 1'b1; TGT_SEG = 3'd3;
    push(4'b0001, t + 1); push(4'b0011, t + 5); push(4'b0111, t + 9);
    chk_bit("idle_busy", BUSY, 1'b0);
    tick();
    REQ = 1'b0;
    while (cyc < t + 14) begin
      if (cyc == t + 10) VCPHV_OK = 1'b1;
      chk_bit("up_busy", BUSY, 1'b1);
      chk_bit("up_ready", READY, 1'b0);
      tick();
    end
    chk_bit("up_ready_t14", READY, 1'b1);
    chk_bit("up_busy_t14", BUSY, 1'b0);
    chk_seg("up_seg_t14", SEG_EN, 4'b0111);

    // Saturating request (7 -> 4) and a request while busy that must be dropped
    t = cyc;
    REQ = 1'b1; TGT_SEG = 3'd7;
    push(4'b1111, t + 1);
    tick();
    REQ = 1'b0;
    chk_bit("sat_busy1", BUSY, 1'b1);
    tick();
    REQ = 1'b1; TGT_SEG = 3'd1;
    tick();
    REQ = 1'b0;
    chk_bit("sat_busy3", BUSY, 1'b1);
    ticks(2);
    chk_bit("sat_check_busy", BUSY, 1'b1);
    chk_bit("sat_check_ready", READY, 1'b0);
    tick();
    chk_bit("sat_ready", READY, 1'b1);
    chk_seg("sat_seg", SEG_EN, 4'b1111);

    // Ramp down to zero: four steps, then IDLE without CHECK
    t = cyc;
    REQ = 1'b1; TGT_SEG = 3'd0;
    push(4'b0111, t + 1); push(4'b0011, t + 5); push(4'b0001, t + 9); push(4'b0000, t + 13);
    tick();
    REQ = 1'b0;
    while (cyc < t + 17) begin
      chk_bit("dn_busy", BUSY, 1'b1);
      chk_bit("dn_ready", READY, 1'b0);
      tick();
    end
    chk_bit("dn_idle_busy", BUSY, 1'b0);
    chk_bit("dn_idle_ready", READY, 1'b0);
    ticks(3);
    chk_bit("dn_no_check_ready", READY, 1'b0);
    chk_bit("dn_no_check_busy", BUSY, 1'b0);
    chk_bit("dn_fault", FAULT, 1'b0);

    // Timeout: target 2 with comparator held low
    VCPHV_OK = 1'b0;
    ticks(3);
    t = cyc;
    REQ = 1'b1; TGT_SEG = 3'd2;
    push(4'b0001, t + 1); push(4'b0011, t + 5); push(4'b0000, t + 17);
    tick();
    REQ = 1'b0;
    while (cyc < t + 17) begin
      chk_bit("to_no_fault", FAULT, 1'b0);
      tick();
    end
    chk_bit("to_fault", FAULT, 1'b1);
    chk_bit("to_busy", BUSY, 1'b0);
    chk_seg("to_seg", SEG_EN, 4'b0000);
    REQ = 1'b1; TGT_SEG = 3'd3;
    tick();
    REQ = 1'b0;
    chk_bit("to_req_ignored", FAULT, 1'b1);
    chk_bit("to_req_busy", BUSY, 1'b0);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk_bit("clr_fault", FAULT, 1'b0);
    chk_bit("clr_busy", BUSY, 1'b0);
    chk_bit("clr_ready", READY, 1'b0);

    // Loss of regulation in READY with a simultaneous request
    VCPHV_OK = 1'b1;
    ticks(3);
    t = cyc;
    REQ = 1'b1; TGT_SEG = 3'd1;
    push(4'b0001, t + 1);
    tick();
    REQ = 1'b0;
    ticks(5);
    chk_bit("lr_ready", READY, 1'b1);
    s = cyc;
    VCPHV_OK = 1'b0;
    push(4'b0000, s + 3);
    tick();
    chk_bit("lr_s1_ready", READY, 1'b1);
    tick();
    chk_bit("lr_s2_ready", READY, 1'b1);
    REQ = 1'b1; TGT_SEG = 3'd4;
    tick();
    REQ = 1'b0;
    chk_bit("lr_fault", FAULT, 1'b1);
    chk_bit("lr_ready_drop", READY, 1'b0);
    chk_bit("lr_busy", BUSY, 1'b0);
    chk_seg("lr_seg", SEG_EN, 4'b0000);
    CLR = 1'b1;
    tick();
    CLR = 1'b0;
    chk_bit("lr_clr", FAULT, 1'b0);

    // Asynchronous reset mid-UP with SEG_EN=0011
    VCPHV_OK = 1'b1;
    t = cyc;
    REQ = 1'b1; TGT_SEG = 3'd4;
    push(4'b0001, t + 1); push(4'b0011, t + 5);
    tick();
    REQ = 1'b0;
    ticks(5);
    chk_seg("mr_seg_before", SEG_EN, 4'b0011);
    push(4'b0000, cyc);
    RESET = 1'b1;
    #1;
    chk_seg("mr_seg", SEG_EN, 4'b0000);
    chk_bit("mr_busy", BUSY, 1'b0);
    chk_bit("mr_ready", READY, 1'b0);
    chk_bit("mr_fault", FAULT, 1'b0);
    tick();
    RESET = 1'b0;
    ticks(2);
    chk_int("sb_drained", sbq.size(), 0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/cap_bank_seq.md
Name: cap_bank_seq

Overview:
- Parametrised successor to the single flash VCPHV capacitance macro: a sequencer that switches NSEG charge-pump capacitor segments onto VCPHV one at a time.
- Each step waits a settle interval, then checks that the VCPHV comparator reports regulation.
- Sits between the flash power controller (REQ/TGT_SEG) and the capacitor macro array (SEG_EN); reports READY/BUSY/FAULT back to the controller.

Parameters:
- NSEG, 4, number of capacitor segments (1..16).
- SW, 3, width of TGT_SEG; must hold NSEG (SW >= ceil(log2(NSEG+1))).
- CW, 8, width of settle/timeout counter.
- SETTLE, 4, cycles each segment step is held before the next step (1..2^CW-1).
- TIMEOUT, 8, cycles allowed in CHECK for VCPHV_OK (1..2^CW-1).

Ports:
- CLK  input  1  clock; all state on rising edge.
- RESET  input  1  asynchronous, active-high reset.
- REQ  input  1  single-cycle request; samples TGT_SEG.
- TGT_SEG  input  SW  target number of enabled segments; values > NSEG saturate to NSEG.
- CLR  input  1  fault clear.
- VCPHV_OK  input  1  asynchronous comparator output (VCPHV in regulation).
- SEG_EN  output  NSEG  thermometer segment enables; bit0 is switched on first.
- BUSY  output  1  high in UP, DOWN, CHECK.
- READY  output  1  high in READY state.
- FAULT  output  1  high in FAULT state.

Behaviour:
- Reset (async, immediate): SEG_EN=0, BUSY=0, READY=0, FAULT=0, state IDLE, counters 0, OK synchroniser 0, tgt register 0.
- VCPHV_OK passes through a 2-flop synchroniser (ok_s). All decisions use ok_s.
- Internal registers:
  - cur: count of set SEG_EN bits. SEG_EN is always the thermometer of cur.
  - tgt: latched, saturated TGT_SEG.
  - cnt: CW-bit down-counter.
- IDLE / READY (REQ=1): latch tgt.
  - tgt>cur: go UP; cur+1 and cnt=SETTLE on the same edge, so the new SEG_EN bit is visible the cycle after REQ.
  - tgt<cur: go DOWN; cur-1 and cnt=SETTLE on the same edge.
  - tgt==cur and tgt>0: go CHECK, cnt=TIMEOUT.
  - tgt==cur==0: stay IDLE.
  - READY drops in the cycle the state leaves READY.
- UP: cnt decrements each cycle. At cnt==1:
  - cur<tgt: cur+1, cnt=SETTLE.
  - cur==tgt: go CHECK, cnt=TIMEOUT.
  - Each segment therefore holds SETTLE cycles before the next bit sets.
- DOWN: mirror of UP, clearing the top set bit per step. When cur==tgt: go CHECK (cnt=TIMEOUT) if tgt>0, otherwise IDLE.
- CHECK:
  - ok_s=1: go READY next edge.
  - Otherwise cnt decrements; ok_s still 0 at cnt==1: go FAULT.
  - Worst case, FAULT is entered TIMEOUT cycles after CHECK entry.
- READY: ok_s==0 in any cycle sends the state to FAULT next edge. A REQ in the same cycle is ignored (fault has priority).
- FAULT: SEG_EN forced to 0 (cur=0) on entry. Stays until CLR=1, then goes IDLE next edge. REQ is ignored in FAULT.
- REQ while BUSY is ignored (no queuing); tgt is unchanged.
- CLR outside FAULT has no effect.
- SEG_EN never changes by more than one bit per edge, except on FAULT entry and reset.
- No output is combinational from inputs; all outputs are registered or decoded from registered state.

Test Plan (NSEG=4, SETTLE=4, TIMEOUT=8, SW=3):
- Reset: assert RESET mid-UP with SEG_EN=0011 -> SEG_EN=0000, BUSY=READY=FAULT=0 immediately, before the next clock edge.
- Ramp up: REQ at edge t, TGT_SEG=3, VCPHV_OK rises at t+10 -> SEG_EN 0001@t+1, 0011@t+5, 0111@t+9; CHECK@t+13; READY=1@t+14; BUSY=1 over t+1..t+13.
- Saturation and ignored request: REQ with TGT_SEG=7 -> final SEG_EN=1111. A second REQ during BUSY with TGT_SEG=1 leaves tgt at 4.
- Ramp down: from READY with 1111, REQ TGT_SEG=0 -> SEG_EN 0111, 0011, 0001, 0000 at 4-cycle spacing; then IDLE with READY=BUSY=0 and no CHECK.
- Timeout: TGT_SEG=2 with VCPHV_OK held 0 -> FAULT=1 exactly TIMEOUT=8 cycles after CHECK entry; SEG_EN=00 in the same cycle. CLR pulse -> IDLE next edge, FAULT=0.
- Loss of regulation: in READY, drop VCPHV_OK at edge s -> ok_s=0 at s+2, FAULT=1 at s+3, SEG_EN=0. A simultaneous REQ is ignored.
